gt_trig_sched: RTL and testbench
================================

GT_TRIG_SCHED -- requirements
Module: gt_trig_sched

Interface
REQ-001 Parameter LATCH_WAIT, default 2: cycles from latch_req to a valid gtin (range 1..7).
REQ-002 Parameter FIFO_DEPTH, default 4: timestamp FIFO entries (power of two, 2..16).
REQ-003 clk  in  1  ADC clock; all logic on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 enable  in  1  trigger acceptance enable.
REQ-006 deadtime  in  8  dead cycles after each capture, sampled when leaving STORE.
REQ-007 trig_self  in  1  self-trigger request, clk-synchronous pulse.
REQ-008 trig_mast  in  1  master-trigger request, clk-synchronous pulse.
REQ-009 gtin  in  25  latched global time {counter[21:0], phase[2:0]} from the latch block.
REQ-010 latch_req  out  1  one-cycle strobe to the latch block trigger input.
REQ-011 busy  out  1  high whenever the state is not IDLE.
REQ-012 ts_data  out  27  {src[1:0], gt[24:0]} at FIFO head, first-word-fall-through.
REQ-013 ts_valid  out  1  FIFO not empty.
REQ-014 ts_rd  in  1  pop strobe; effective only when ts_valid=1.
REQ-015 fifo_cnt  out  5  current FIFO occupancy.
REQ-016 overflow  out  1  sticky: a capture was dropped because the FIFO was full.
REQ-017 lost_cnt  out  16  triggers rejected while busy or disabled (see Configuration).

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, STORE and DEAD.
REQ-019 IDLE: if enable=1 and (trig_self|trig_mast), the block SHALL assert latch_req for exactly one cycle, register src={trig_mast,trig_self}, and enter WAIT.
REQ-020 Simultaneous trig_self and trig_mast SHALL produce one capture with src=2'b11.
REQ-021 WAIT SHALL last exactly LATCH_WAIT cycles, then go to STORE.
REQ-022 STORE SHALL last one cycle and push {src,gtin} if the FIFO is not full, or if it is full and ts_rd=1 in the same cycle; otherwise it SHALL drop the entry and set overflow.
REQ-023 After STORE the FSM SHALL enter DEAD for deadtime cycles; deadtime=0 SHALL go directly to IDLE.
REQ-024 With LATCH_WAIT=2: trig sampled at edge N -> latch_req high N..N+1, gtin sampled at edge N+3, ts_valid high after N+3 if the FIFO was empty, earliest next acceptance at edge N+4+deadtime.
REQ-025 Each cycle that trig_self|trig_mast=1 while not accepted (busy, or enable=0) SHALL increment lost_cnt by 1; lost_cnt SHALL saturate at 16'hFFFF.
REQ-026 Deasserting enable outside IDLE SHALL NOT abort the sequence in progress.
REQ-027 ts_rd with ts_valid=0 SHALL be ignored; pointers SHALL wrap modulo FIFO_DEPTH.
REQ-028 fifo_cnt SHALL be updated on the same edge as the push or pop, with simultaneous push and pop leaving it unchanged.

Reset
REQ-029 reset SHALL force state IDLE, latch_req=0, busy=0, FIFO empty (ts_valid=0, fifo_cnt=0), overflow=0, lost_cnt=0, and ts_data=0.
REQ-030 reset asserted mid-sequence SHALL discard the pending capture, and no latch_req SHALL be issued in the reset cycle.

Configuration
REQ-031 Macro GTSCHED_LOSTCNT_EN: when defined, lost_cnt SHALL behave per REQ-025; when undefined, the counter logic SHALL be absent and lost_cnt SHALL be tied to 0.

Verification
REQ-032 Single capture: trig_self pulse with gtin=25'h0ABCDE and deadtime=0 -> one latch_req, ts_data=27'h00ABCDE|(2'b01<<25) three edges later, fifo_cnt=1.
REQ-033 Simultaneous trig_self and trig_mast -> one entry with src=2'b11 and lost_cnt unchanged.
REQ-034 deadtime=5 with back-to-back triggers every cycle for 20 cycles -> captures 9 cycles apart, every non-accepted cycle counted in lost_cnt.
REQ-035 Fill the FIFO with 4 captures and no ts_rd, then a 5th trigger -> entry dropped, overflow=1, fifo_cnt=4; repeat with ts_rd in the STORE cycle -> push accepted, fifo_cnt stays 4.
REQ-036 Assert reset during WAIT -> next cycle busy=0, ts_valid=0, overflow=0, no entry pushed.
REQ-037 enable=0 with 3 trigger pulses -> no latch_req, lost_cnt=3 (0 when GTSCHED_LOSTCNT_EN is undefined).

Source files
------------

// File: rtl/gt_trig_sched_if.sv
// Trigger scheduler bus: trigger inputs, latch handshake, and timestamp FIFO read port.
// The slave modport is the scheduler side; the master modport is the driving side.
interface gt_trig_sched_if;
    logic        enable;
    logic [7:0]  deadtime;
    logic        trig_self;
    logic        trig_mast;
    logic [24:0] gtin;
    logic        latch_req;
    logic        busy;
    logic [26:0] ts_data;
    logic        ts_valid;
    logic        ts_rd;
    logic [4:0]  fifo_cnt;
    logic        overflow;
    logic [15:0] lost_cnt;

    modport master (
        output enable, deadtime, trig_self, trig_mast, gtin, ts_rd,
        input  latch_req, busy, ts_data, ts_valid, fifo_cnt, overflow, lost_cnt
    );

    modport slave (
        input  enable, deadtime, trig_self, trig_mast, gtin, ts_rd,
        output latch_req, busy, ts_data, ts_valid, fifo_cnt, overflow, lost_cnt
    );
endinterface

// File: rtl/gt_trig_sched.sv
// Trigger scheduler: accepts self/master triggers, strobes the global-time latch, queues
// {src, gt} timestamps in a FWFT FIFO. Define GTSCHED_LOSTCNT_EN to count rejected triggers.
module gt_trig_sched #(
    parameter int unsigned LATCH_WAIT = 2,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input logic            clk,
    input logic            reset,
    gt_trig_sched_if.slave bus
);
    localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
    localparam logic [2:0]  WaitInit = 3'(LATCH_WAIT - 1);
    localparam logic [4:0]  DepthCnt = 5'(FIFO_DEPTH);

    typedef enum logic [1:0] {StIdle, StWait, StStore, StDead} state_e;

    state_e          state_q;
    logic [2:0]      wait_cnt_q;
    logic [7:0]      dead_cnt_q;
    logic [1:0]      src_q;
    logic            latch_req_q;
    logic            busy_q;
    logic            overflow_q;
    logic [26:0]     mem [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q;
    logic [PtrW-1:0] rd_ptr_q;
    logic [4:0]      cnt_q;

    logic trig_any;
    logic accept;
    logic empty;
    logic full;
    logic pop;
    logic push;

    assign trig_any = bus.trig_self | bus.trig_mast;
    assign accept   = (state_q == StIdle) && bus.enable && trig_any;
    assign empty    = (cnt_q == 5'd0);
    assign full     = (cnt_q == DepthCnt);
    assign pop      = bus.ts_rd && !empty;
    // A full FIFO still accepts the store when the head is being popped on the same edge.
    assign push     = (state_q == StStore) && (!full || pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            wait_cnt_q  <= 3'd0;
            dead_cnt_q  <= 8'd0;
            src_q       <= 2'b00;
            latch_req_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            latch_req_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (accept) begin
                        latch_req_q <= 1'b1;
                        busy_q      <= 1'b1;
                        src_q       <= {bus.trig_mast, bus.trig_self};
                        wait_cnt_q  <= WaitInit;
                        state_q     <= StWait;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q <= StStore;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                StStore: begin
                    if (bus.deadtime == 8'd0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        dead_cnt_q <= bus.deadtime - 8'd1;
                        state_q    <= StDead;
                    end
                end
                StDead: begin
                    if (dead_cnt_q == 8'd0) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end else begin
                        dead_cnt_q <= dead_cnt_q - 8'd1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= {src_q, bus.gtin};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= 5'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + 5'd1;
                2'b01:   cnt_q <= cnt_q - 5'd1;
                default: cnt_q <= cnt_q;
            endcase
            if ((state_q == StStore) && !push) begin
                overflow_q <= 1'b1;
            end
        end
    end

`ifdef GTSCHED_LOSTCNT_EN
    logic [15:0] lost_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lost_q <= 16'd0;
        end else if (trig_any && !accept && (lost_q != 16'hFFFF)) begin
            lost_q <= lost_q + 16'd1;
        end
    end

    assign bus.lost_cnt = lost_q;
`else
    assign bus.lost_cnt = 16'd0;
`endif

    assign bus.latch_req = latch_req_q;
    assign bus.busy      = busy_q;
    assign bus.ts_valid  = !empty;
    assign bus.ts_data   = empty ? 27'd0 : mem[rd_ptr_q];
    assign bus.fifo_cnt  = cnt_q;
    assign bus.overflow  = overflow_q;
endmodule

// File: tb/tb_gt_trig_sched.sv
// Directed bench for gt_trig_sched; expected timestamps are queued when a capture is
// expected and compared when read from the FIFO head.
module tb_gt_trig_sched;
`ifdef GTSCHED_LOSTCNT_EN
    localparam bit LostEn = 1'b1;
`else
    localparam bit LostEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    int          n_tests = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          lr_cnt = 0;
    int          lr_cyc[$];
    logic [26:0] sb[$];
    int          exp_lost = 0;

    gt_trig_sched_if bus ();

    gt_trig_sched #(
        .LATCH_WAIT(2),
        .FIFO_DEPTH(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.latch_req === 1'b1) begin
            lr_cnt <= lr_cnt + 1;
            lr_cyc.push_back(cyc);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lost_exp();
        return LostEn ? 32'(exp_lost) : 32'd0;
    endfunction

    task automatic pulse(input logic s, input logic m);
        bus.trig_self = s;
        bus.trig_mast = m;
        step();
        bus.trig_self = 1'b0;
        bus.trig_mast = 1'b0;
    endtask

    task automatic read_one(input string tag);
        logic [26:0] e;
        if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $error("FAIL %s_sb observed=empty expected=entry", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_valid"}, 32'(bus.ts_valid), 32'd1);
            chk({tag, "_data"}, 32'(bus.ts_data), 32'(e));
        end
        bus.ts_rd = 1'b1;
        step();
        bus.ts_rd = 1'b0;
    endtask

    initial begin
        int base;
        int g1;
        int g2;

        bus.enable    = 1'b1;
        bus.deadtime  = 8'd0;
        bus.trig_self = 1'b0;
        bus.trig_mast = 1'b0;
        bus.gtin      = 25'd0;
        bus.ts_rd     = 1'b0;
        step();
        step();
        reset = 1'b0;

        // Reset state
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_latch", 32'(bus.latch_req), 32'd0);
        chk("rst_valid", 32'(bus.ts_valid), 32'd0);
        chk("rst_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("rst_ovf", 32'(bus.overflow), 32'd0);
        chk("rst_lost", 32'(bus.lost_cnt), 32'd0);
        chk("rst_data", 32'(bus.ts_data), 32'd0);

        // Single capture, deadtime 0
        bus.gtin = 25'h0ABCDE;
        pulse(1'b1, 1'b0);
        chk("single_latch_hi", 32'(bus.latch_req), 32'd1);
        chk("single_busy", 32'(bus.busy), 32'd1);
        step();
        chk("single_latch_lo", 32'(bus.latch_req), 32'd0);
        step();
        chk("single_not_yet", 32'(bus.ts_valid), 32'd0);
        step();
        sb.push_back(27'h20ABCDE);
        chk("single_cnt", 32'(bus.fifo_cnt), 32'd1);
        chk("single_idle", 32'(bus.busy), 32'd0);
        read_one("single");
        chk("single_latches", 32'(lr_cnt), 32'd1);

        // Simultaneous triggers
        bus.gtin = 25'h1234567;
        pulse(1'b1, 1'b1);
        repeat (3) step();
        sb.push_back({2'b11, 25'h1234567});
        chk("both_cnt", 32'(bus.fifo_cnt), 32'd1);
        chk("both_lost", 32'(bus.lost_cnt), lost_exp());
        read_one("both");

        // Deadtime 5 with a trigger every cycle for 20 cycles
        bus.deadtime = 8'd5;
        bus.gtin = 25'h0055AA;
        base = lr_cnt;
        bus.trig_self = 1'b1;
        repeat (20) step();
        bus.trig_self = 1'b0;
        exp_lost += 17;
        repeat (3) sb.push_back({2'b01, 25'h0055AA});
        repeat (12) step();
        chk("dt_captures", 32'(lr_cnt - base), 32'd3);
        g1 = (lr_cyc.size() > base + 1) ? lr_cyc[base + 1] - lr_cyc[base] : -1;
        g2 = (lr_cyc.size() > base + 2) ? lr_cyc[base + 2] - lr_cyc[base + 1] : -1;
        chk("dt_gap1", 32'(g1), 32'd9);
        chk("dt_gap2", 32'(g2), 32'd9);
        chk("dt_cnt", 32'(bus.fifo_cnt), 32'd3);
        chk("dt_lost", 32'(bus.lost_cnt), lost_exp());
        read_one("dt0");
        read_one("dt1");
        read_one("dt2");
        bus.deadtime = 8'd0;

        // Fill, overflow, then full-with-pop in the STORE cycle
        for (int i = 0; i < 4; i++) begin
            bus.gtin = 25'h100 + 25'(i);
            pulse(1'b1, 1'b0);
            repeat (3) step();
            sb.push_back({2'b01, 25'h100 + 25'(i)});
        end
        chk("fill_cnt", 32'(bus.fifo_cnt), 32'd4);
        chk("fill_ovf", 32'(bus.overflow), 32'd0);
        bus.gtin = 25'h1FFFFFF;
        pulse(1'b1, 1'b0);
        repeat (3) step();
        chk("ovf_flag", 32'(bus.overflow), 32'd1);
        chk("ovf_cnt", 32'(bus.fifo_cnt), 32'd4);
        bus.gtin = 25'h0000777;
        pulse(1'b0, 1'b1);
        step();
        step();
        if (sb.size() != 0) begin
            chk("popstore_head", 32'(bus.ts_data), 32'(sb.pop_front()));
        end
        sb.push_back({2'b10, 25'h0000777});
        bus.ts_rd = 1'b1;
        step();
        bus.ts_rd = 1'b0;
        chk("popstore_cnt", 32'(bus.fifo_cnt), 32'd4);
        chk("popstore_ovf", 32'(bus.overflow), 32'd1);
        for (int i = 0; i < 4; i++) read_one($sformatf("drain%0d", i));
        chk("drain_cnt", 32'(bus.fifo_cnt), 32'd0);
        bus.ts_rd = 1'b1;
        step();
        bus.ts_rd = 1'b0;
        chk("empty_rd_cnt", 32'(bus.fifo_cnt), 32'd0);
        chk("empty_rd_valid", 32'(bus.ts_valid), 32'd0);

        // Reset during WAIT discards the capture and clears sticky state
        bus.gtin = 25'h0BEEF;
        pulse(1'b1, 1'b0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        exp_lost = 0;
        chk("rw_busy", 32'(bus.busy), 32'd0);
        chk("rw_valid", 32'(bus.ts_valid), 32'd0);
        chk("rw_ovf", 32'(bus.overflow), 32'd0);
        chk("rw_lost", 32'(bus.lost_cnt), 32'd0);
        repeat (4) step();
        chk("rw_no_push", 32'(bus.fifo_cnt), 32'd0);
        reset = 1'b1;
        bus.trig_self = 1'b1;
        step();
        reset = 1'b0;
        bus.trig_self = 1'b0;
        chk("rst_trig_latch", 32'(bus.latch_req), 32'd0);
        chk("rst_trig_busy", 32'(bus.busy), 32'd0);

        // Disabled: pulses are counted but not captured
        bus.enable = 1'b0;
        base = lr_cnt;
        repeat (3) begin
            pulse(1'b1, 1'b0);
            step();
        end
        exp_lost += 3;
        chk("dis_latch", 32'(lr_cnt - base), 32'd0);
        chk("dis_lost", 32'(bus.lost_cnt), lost_exp());
        chk("dis_cnt", 32'(bus.fifo_cnt), 32'd0);

        // Dropping enable mid-sequence does not abort it
        bus.enable = 1'b1;
        bus.gtin = 25'h0C0FFEE;
        pulse(1'b0, 1'b1);
        bus.enable = 1'b0;
        repeat (3) step();
        sb.push_back({2'b10, 25'h0C0FFEE});
        chk("en_drop_cnt", 32'(bus.fifo_cnt), 32'd1);
        read_one("en_drop");
        bus.enable = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
